// File: rtl/maxpool_window_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : maxpool_window_gen_if
// Brief    : Pixel-in / 3x3-window-out stream bundle for maxpool_window_gen.
// Revision : 1.0 - initial release
// ============================================================================
interface maxpool_window_gen_if #(
   parameter int DATA_W = 16
);
   logic                pix_valid;
   logic [DATA_W-1:0]   pix_data;
   logic                win_valid;
   logic [9*DATA_W-1:0] win_data;
   logic                frame_done;

   // master = pixel source / window consumer, slave = the window generator
   modport master (
      output pix_valid, pix_data,
      input  win_valid, win_data, frame_done
   );
   modport slave (
      input  pix_valid, pix_data,
      output win_valid, win_data, frame_done
   );
endinterface
`default_nettype wire

// File: rtl/maxpool_window_gen.sv
`default_nettype none
// ============================================================================
// Module   : maxpool_window_gen
// Brief    : Raster-stream 3x3 window generator feeding a max-pool stage.
//            Optional WINGEN_STATS_EN adds a per-frame window counter.
// Revision : 1.0 - initial release
// ============================================================================
module maxpool_window_gen #(
   parameter int DATA_W = 16,
   parameter int IMG_W  = 224,
   parameter int IMG_H  = 224,
   parameter int STRIDE = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   maxpool_window_gen_if.slave  win_if
`ifdef WINGEN_STATS_EN
   ,
   output logic [15:0]          win_count
`endif
);

   localparam int c_col_w = $clog2(IMG_W);
   localparam int c_row_w = $clog2(IMG_H);
   localparam logic [c_col_w-1:0] c_col_last = c_col_w'(IMG_W - 1);
   localparam logic [c_row_w-1:0] c_row_last = c_row_w'(IMG_H - 1);

   logic [c_col_w-1:0] col_q, col_d;
   logic [c_row_w-1:0] row_q, row_d;
   logic               col_ph_q, col_ph_d, col_ph_step;
   logic               row_ph_q, row_ph_d, row_ph_step;

   logic [DATA_W-1:0]  lb0_q [IMG_W];
   logic [DATA_W-1:0]  lb1_q [IMG_W];
   logic [DATA_W-1:0]  win_q [9];
   logic [DATA_W-1:0]  win_d [9];
   logic [9*DATA_W-1:0] win_pack;

   logic               win_valid_q;
   logic               frame_done_q;
   logic [9*DATA_W-1:0] win_data_q;

   logic               accept;
   logic               col_wrap;
   logic               row_wrap;
   logic               win_hit;
   logic [DATA_W-1:0]  lb0_rd;
   logic [DATA_W-1:0]  lb1_rd;

   assign accept   = win_if.pix_valid;
   assign col_wrap = (col_q == c_col_last);
   assign row_wrap = (row_q == c_row_last);
   assign lb0_rd   = lb0_q[col_q];
   assign lb1_rd   = lb1_q[col_q];

   // Phase bit = (index - 2) mod STRIDE, restarted at every wrap so odd sizes stay aligned.
   generate
      if (STRIDE == 2) begin : g_stride2
         assign col_ph_step = col_wrap ? 1'b0 : ~col_ph_q;
         assign row_ph_step = row_wrap ? 1'b0 : ~row_ph_q;
      end else begin : g_stride1
         assign col_ph_step = 1'b0;
         assign row_ph_step = 1'b0;
      end
   endgenerate

   assign win_hit = (row_q >= c_row_w'(2)) && (col_q >= c_col_w'(2)) &&
                    !row_ph_q && !col_ph_q;

   always_comb begin
      col_d    = col_q;
      row_d    = row_q;
      col_ph_d = col_ph_q;
      row_ph_d = row_ph_q;
      if (accept) begin
         col_d    = col_wrap ? '0 : col_q + 1'b1;
         col_ph_d = col_ph_step;
         if (col_wrap) begin
            row_d    = row_wrap ? '0 : row_q + 1'b1;
            row_ph_d = row_ph_step;
         end
      end
   end

   // Window after this pixel: shift left, new right column is {lb1, lb0, pixel}.
   always_comb begin
      win_pack = '0;
      for (int r = 0; r < 3; r++) begin
         win_d[r*3+0] = win_q[r*3+1];
         win_d[r*3+1] = win_q[r*3+2];
      end
      win_d[2] = lb1_rd;
      win_d[5] = lb0_rd;
      win_d[8] = win_if.pix_data;
      for (int k = 0; k < 9; k++) begin
         win_pack[k*DATA_W +: DATA_W] = win_d[k];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         col_q        <= '0;
         row_q        <= '0;
         col_ph_q     <= 1'b0;
         row_ph_q     <= 1'b0;
         win_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
         win_data_q   <= '0;
      end else begin
         col_q        <= col_d;
         row_q        <= row_d;
         col_ph_q     <= col_ph_d;
         row_ph_q     <= row_ph_d;
         win_valid_q  <= accept && win_hit;
         frame_done_q <= accept && col_wrap && row_wrap;
         if (accept && win_hit) begin
            win_data_q <= win_pack;
         end
      end
   end

   // Storage needs no reset: gating on row/col >= 2 only ever exposes freshly written entries.
   always_ff @(posedge clk) begin
      if (accept) begin
         lb0_q[col_q] <= win_if.pix_data;
         lb1_q[col_q] <= lb0_rd;
         win_q        <= win_d;
      end
   end

   assign win_if.win_valid  = win_valid_q;
   assign win_if.win_data   = win_data_q;
   assign win_if.frame_done = frame_done_q;

`ifdef WINGEN_STATS_EN
   logic [15:0] win_count_q;

   // Updates on the same edge as win_valid so the final pulse is included at frame_done.
   always_ff @(posedge clk) begin
      if (rst || frame_done_q) begin
         win_count_q <= '0;
      end else if (accept && win_hit && (win_count_q != 16'hFFFF)) begin
         win_count_q <= win_count_q + 16'd1;
      end
   end

   assign win_count = win_count_q;
`endif

endmodule
`default_nettype wire
